// File: rtl/hamming_dec_serial_if.sv
// Serial Hamming(11,7) decoder handshake bundle: bit-serial input side,
// word-parallel output side and the optional corrected-word counter.
interface hamming_dec_serial_if;
  logic       ser_in;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] data_out;
  logic [3:0] syndrome;
  logic       err_corr;
  logic       err_uncorr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] corr_count;

  // The decoder is the slave; the producer/consumer pair is the master.
  modport slave (
    input  ser_in, in_valid, out_ready,
    output in_ready, data_out, syndrome, err_corr, err_uncorr, out_valid, corr_count
  );

  modport master (
    output ser_in, in_valid, out_ready,
    input  in_ready, data_out, syndrome, err_corr, err_uncorr, out_valid, corr_count
  );
endinterface

// File: rtl/hamming_dec_serial.sv
// Bit-serial Hamming(11,7) SEC decoder: collects 11 bits (position 1 first),
// corrects single errors, flags syndromes 12..15. Optional HAMMING_DEC_STATS_EN.
module hamming_dec_serial (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_dec_serial_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q;
  logic [10:0] code_q;       // bit i holds codeword position i+1
  logic [6:0]  data_q;
  logic [3:0]  syn_q;
  logic        err_corr_q;
  logic        err_uncorr_q;

  logic        in_ready;
  logic        out_valid;
  logic        accept;
  logic        last_bit;
  logic        out_fire;

  logic [3:0]  syn_d;
  logic [10:0] flip_mask;
  logic [10:0] fixed;

  assign accept   = bus.in_valid && in_ready;
  assign last_bit = accept && (bit_cnt_q == 4'd10);
  assign out_fire = out_valid && bus.out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        in_ready = 1'b1;
        if (last_bit) state_d = CHECK;
      end
      CHECK: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_fire) state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      code_q    <= '0;
    end else begin
      state_q <= state_d;
      if (last_bit)    bit_cnt_q <= '0;
      else if (accept) bit_cnt_q <= bit_cnt_q + 4'd1;
      if (accept) code_q[bit_cnt_q] <= bus.ser_in;
    end
  end

  // Syndrome bit k re-checks parity P(k) against the data bits it covers.
  always_comb begin
    syn_d[0] = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6] ^ code_q[8] ^ code_q[10];
    syn_d[1] = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6] ^ code_q[9] ^ code_q[10];
    syn_d[2] = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
    syn_d[3] = code_q[7] ^ code_q[8] ^ code_q[9] ^ code_q[10];
  end

  // Syndromes 0 and 12..15 match no position, so they leave the word untouched.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < 11; i++) begin
      flip_mask[i] = (syn_d == 4'(i + 1));
    end
    fixed = code_q ^ flip_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q       <= '0;
      syn_q        <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
    end else if (state_q == CHECK) begin
      data_q       <= {fixed[10], fixed[9], fixed[8], fixed[6], fixed[5], fixed[4], fixed[2]};
      syn_q        <= syn_d;
      err_corr_q   <= (syn_d != 4'd0) && (syn_d <= 4'd11);
      err_uncorr_q <= (syn_d >= 4'd12);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.data_out   = data_q;
  assign bus.syndrome   = syn_q;
  assign bus.err_corr   = err_corr_q;
  assign bus.err_uncorr = err_uncorr_q;

`ifdef HAMMING_DEC_STATS_EN
  logic [7:0] corr_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_count_q <= '0;
    end else if (out_fire && err_corr_q && (corr_count_q != 8'hFF)) begin
      corr_count_q <= corr_count_q + 8'd1;
    end
  end

  assign bus.corr_count = corr_count_q;
`else
  assign bus.corr_count = 8'h00;
`endif

endmodule

// File: tb/tb_hamming_dec_serial.sv
// Directed + random scoreboard bench for hamming_dec_serial; expected words are
// queued when a codeword is sent and popped at the output handshake.
module tb_hamming_dec_serial;

  typedef struct packed {
    logic [6:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       uncorr;
  } exp_t;

`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  // Clean encoding of data 7'h4D, position 1 in bit 0.
  localparam logic [10:0] CW_4D = 11'b100_1110_0101;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_corr = 0;
  exp_t sb_q[$];

  hamming_dec_serial_if bus ();

  hamming_dec_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] encode(input logic [6:0] d);
    logic [10:0] c;
    c[2]  = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[8]  = d[4]; c[9] = d[5]; c[10] = d[6];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3];
    c[7]  = d[4] ^ d[5] ^ d[6];
    return c;
  endfunction

  function automatic logic [10:0] flip(input logic [10:0] c, input int pos);
    return c ^ (11'd1 << (pos - 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    exp_corr = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, "_data"},       32'(bus.data_out),   32'd0);
    check({tag, "_syndrome"},   32'(bus.syndrome),   32'd0);
    check({tag, "_err_corr"},   32'(bus.err_corr),   32'd0);
    check({tag, "_err_uncorr"}, 32'(bus.err_uncorr), 32'd0);
    check({tag, "_corr_count"}, 32'(bus.corr_count), 32'd0);
  endtask

  // Sends 11 bits; after bit index gap_idx (if 0..10) in_valid drops for 3 cycles.
  task automatic send_word(input logic [10:0] cw, input int gap_idx);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("in_ready_shift", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.ser_in   = cw[i];
      if (i == gap_idx) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("check_out_valid", 32'(bus.out_valid), 32'd0);
    check("check_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    check("out_valid_latency", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic compare_word(input string tag, input exp_t e);
    check({tag, "_data"},       32'(bus.data_out),   32'(e.data));
    check({tag, "_syndrome"},   32'(bus.syndrome),   32'(e.syn));
    check({tag, "_err_corr"},   32'(bus.err_corr),   32'(e.corr));
    check({tag, "_err_uncorr"}, 32'(bus.err_uncorr), 32'(e.uncorr));
  endtask

  // Pops the scoreboard at the output; holds out_ready low for 'stall' cycles first.
  task automatic consume(input string tag, input int stall);
    exp_t e;
    for (int k = 0; k < 4 && bus.out_valid !== 1'b1; k++) @(negedge clk);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    compare_word(tag, e);
    bus.out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      compare_word({tag, "_hold"}, e);
      check({tag, "_hold_valid"},    32'(bus.out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready),  32'd0);
      if (s == stall - 1) bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"},    32'(bus.out_valid), 32'd0);
    check({tag, "_next_in_ready"}, 32'(bus.in_ready),  32'd1);
    if (e.corr && exp_corr < 255) exp_corr++;
    check({tag, "_corr_count"}, 32'(bus.corr_count), STATS_EN ? 32'(exp_corr) : 32'd0);
  endtask

  initial begin
    logic [6:0] d;
    int         p;

    rst_n         = 1'b0;
    bus.ser_in    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    // Clean word.
    sb_q.push_back('{data: 7'h4D, syn: 4'h0, corr: 1'b0, uncorr: 1'b0});
    send_word(CW_4D, -1);
    consume("clean", 0);

    // Data-bit error at position 6.
    sb_q.push_back('{data: 7'h4D, syn: 4'h6, corr: 1'b1, uncorr: 1'b0});
    send_word(flip(CW_4D, 6), -1);
    consume("err_pos6", 0);

    // Double error at positions 4 and 8: uncorrectable.
    sb_q.push_back('{data: 7'h4D, syn: 4'hC, corr: 1'b0, uncorr: 1'b1});
    send_word(flip(flip(CW_4D, 4), 8), -1);
    consume("uncorr", 0);

    // Parity-position corrections leave the data alone; position 11 is the last bit.
    sb_q.push_back('{data: 7'h4D, syn: 4'h8, corr: 1'b1, uncorr: 1'b0});
    send_word(flip(CW_4D, 8), -1);
    consume("err_pos8", 0);
    sb_q.push_back('{data: 7'h4D, syn: 4'hB, corr: 1'b1, uncorr: 1'b0});
    send_word(flip(CW_4D, 11), -1);
    consume("err_pos11", 0);
    sb_q.push_back('{data: 7'h7F, syn: 4'h1, corr: 1'b1, uncorr: 1'b0});
    send_word(flip(encode(7'h7F), 1), -1);
    consume("ones_pos1", 0);
    sb_q.push_back('{data: 7'h00, syn: 4'h0, corr: 1'b0, uncorr: 1'b0});
    send_word(encode(7'h00), -1);
    consume("zeros", 0);

    // Backpressure: out_ready low for 5 cycles.
    sb_q.push_back('{data: 7'h4D, syn: 4'h3, corr: 1'b1, uncorr: 1'b0});
    send_word(flip(CW_4D, 3), -1);
    consume("stall", 5);

    // Stream gap of 3 cycles after bit 5.
    sb_q.push_back('{data: 7'h4D, syn: 4'h0, corr: 1'b0, uncorr: 1'b0});
    send_word(CW_4D, 4);
    consume("gap", 0);

    // Reset after 7 bits of a corrupted word; the next word decodes fresh.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ser_in   = ~CW_4D[i];
    end
    do_reset();
    check_reset_state("mid_reset");
    sb_q.push_back('{data: 7'h4D, syn: 4'h0, corr: 1'b0, uncorr: 1'b0});
    send_word(CW_4D, -1);
    consume("after_reset", 0);

    // Reset while a word is pending in OUT discards it.
    sb_q.push_back('{data: 7'h2A, syn: 4'h5, corr: 1'b1, uncorr: 1'b0});
    send_word(flip(encode(7'h2A), 5), -1);
    do_reset();
    check_reset_state("out_reset");

    // 300 single-error words drive the counter into saturation.
    for (int w = 0; w < 300; w++) begin
      d = 7'($urandom_range(0, 127));
      p = $urandom_range(1, 11);
      sb_q.push_back('{data: d, syn: 4'(p), corr: 1'b1, uncorr: 1'b0});
      send_word(flip(encode(d), p), -1);
      consume("rand", 0);
    end
    check("corr_count_sat", 32'(bus.corr_count), STATS_EN ? 32'hFF : 32'h0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
